// File: rtl/timer_sequencer_pkg.sv
// Types shared by the timer sequencer slice.
// The optional prescaler is enabled by TIMER_SEQ_PRESCALE_EN.
`include "timer_seq_defs.vh"

package timer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `ST_IDLE,
    ST_RUN  = `ST_RUN,
    ST_HOLD = `ST_HOLD
  } state_t;

  // Modulo-2**w increment of the count.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input int w);
    logic [7:0] r;
    r = v + 8'd1;
    r = r & ((8'd1 << w) - 8'd1);
    return r;
  endfunction

endpackage

// File: rtl/timer_sequencer_if.sv
// Control/status bundle between system control logic and the timer sequencer.
// presc_div exists only when TIMER_SEQ_PRESCALE_EN is defined.
interface timer_sequencer_if #(
  parameter int WIDTH = 3
`ifdef TIMER_SEQ_PRESCALE_EN
  , parameter int PRESC_W = 2
`endif
);

  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
`ifdef TIMER_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] presc_div;
`endif
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, auto_reload, load_val, term_val,
`ifdef TIMER_SEQ_PRESCALE_EN
    output presc_div,
`endif
    input  cnt, busy, done
  );

  modport slave (
    input  start, stop, pause, auto_reload, load_val, term_val,
`ifdef TIMER_SEQ_PRESCALE_EN
    input  presc_div,
`endif
    output cnt, busy, done
  );

endinterface

// File: rtl/timer_seq_defs.vh
// Shared state encodings for the timer sequencer.
// Encoding 2'd3 is unused; the FSM recovers from it to IDLE on the next edge.
`ifndef TIMER_SEQ_DEFS_VH
`define TIMER_SEQ_DEFS_VH

`define ST_IDLE 2'd0
`define ST_RUN  2'd1
`define ST_HOLD 2'd2

`endif

// File: rtl/timer_seq_presc.sv
// Clock prescaler: emits a tick every div+1 enabled clocks.
// Only instantiated when TIMER_SEQ_PRESCALE_EN is defined.
module timer_seq_presc #(
  parameter int PRESC_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_q, presc_d;

  assign tick = en && !clr && (presc_q == div);

  // Next prescaler value: clear wins, wrap on tick, advance when enabled.
  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Run-control for an up-counter: start/restart from load_val, pause, stop,
// terminal-count detect with optional auto-reload and a registered done pulse.
// Define TIMER_SEQ_PRESCALE_EN to gate counting with a programmable prescaler.
//
// state   | meaning
// IDLE    | counter stopped, cnt holds
// RUN     | counting on each tick, compares against term_val
// HOLD    | paused, cnt and prescaler hold
import timer_sequencer_pkg::*;

module timer_sequencer #(
  parameter int WIDTH = 3
`ifdef TIMER_SEQ_PRESCALE_EN
  , parameter int PRESC_W = 2
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  timer_sequencer_if.slave    bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef TIMER_SEQ_PRESCALE_EN
  logic presc_clr;
  logic presc_en;

  // Any leaving or (re)entry of the run sequence restarts the division period.
  assign presc_clr = bus.stop || bus.start ||
                     !((state_q == ST_RUN) || (state_q == ST_HOLD));
  assign presc_en  = (state_q == ST_RUN) && !bus.pause;

  timer_seq_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (presc_en),
    .div   (bus.presc_div),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Next state, count and done pulse; priority stop > start > pause > tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.stop && bus.start) begin
          state_d = ST_RUN;
          cnt_d   = bus.load_val;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          cnt_d = bus.load_val;
        end else if (bus.pause) begin
          state_d = ST_HOLD;
        end else if (tick) begin
          if (cnt_q == bus.term_val) begin
            done_d = 1'b1;
            if (bus.auto_reload) begin
              cnt_d = bus.load_val;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
      ST_HOLD: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = bus.load_val;
        end else if (!bus.pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, count and done registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer. Stimulus is applied on the falling
// edge and the expected post-edge outputs are queued; a monitor pops and
// compares shortly after each rising edge. Prescaler cases run only when
// TIMER_SEQ_PRESCALE_EN is defined.
module tb_timer_sequencer;

  localparam int W = 3;

  logic clk;
  logic rst_n;

  timer_sequencer_if #(.WIDTH(W)) bus ();

  timer_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string          nm;
    logic [W-1:0]   cnt;
    logic           busy;
    logic           done;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int cfg_ld = 0;
  int cfg_tm = 7;
  logic cfg_ar = 1'b0;
  int cfg_pd = 2;

  int   t3_cnt  [8] = '{7, 0, 1, 6, 7, 0, 1, 6};
  logic t3_done [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int   t6_cnt  [7] = '{0, 0, 1, 1, 1, 2, 2};
  int   t6b_cnt [3] = '{0, 0, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic st, input logic sp, input logic pa,
                     input int ec, input logic eb, input logic ed, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n           = r;
    bus.start       = st;
    bus.stop        = sp;
    bus.pause       = pa;
    bus.load_val    = W'(cfg_ld);
    bus.term_val    = W'(cfg_tm);
    bus.auto_reload = cfg_ar;
`ifdef TIMER_SEQ_PRESCALE_EN
    bus.presc_div   = 2'(cfg_pd);
`endif
    e.nm   = nm;
    e.cnt  = W'(ec);
    e.busy = eb;
    e.done = ed;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so compare one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s cnt: got %0d expected %0d at %0t", e.nm, bus.cnt, e.cnt, $time);
        end
        n_checks++;
        if (bus.busy !== e.busy) begin
          n_fail++;
          $display("FAIL %s busy: got %b expected %b at %0t", e.nm, bus.busy, e.busy, $time);
        end
        n_checks++;
        if (bus.done !== e.done) begin
          n_fail++;
          $display("FAIL %s done: got %b expected %b at %0t", e.nm, bus.done, e.done, $time);
        end
      end
    end
  end

  initial begin
    int budget;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.pause       = 1'b0;
    bus.auto_reload = 1'b0;
    bus.load_val    = '0;
    bus.term_val    = '0;
`ifdef TIMER_SEQ_PRESCALE_EN
    bus.presc_div   = 2'd2;
`endif

    // Reset held with start asserted.
    cfg_ld = 5; cfg_tm = 7; cfg_ar = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "reset");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "reset");

`ifdef TIMER_SEQ_PRESCALE_EN
    // Divide-by-3 counting, then restart mid-period.
    cfg_ld = 0; cfg_tm = 7; cfg_ar = 1'b0; cfg_pd = 2;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, "ps_start");
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, t6_cnt[i], 1'b1, 1'b0, "ps_count");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, "ps_restart");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, t6b_cnt[i], 1'b1, 1'b0, "ps_after_restart");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, "ps_stop");
`else
    // One-shot 0..7.
    cfg_ld = 0; cfg_tm = 7; cfg_ar = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, "os_start");
    for (int i = 1; i <= 7; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, i, 1'b1, 1'b0, "os_count");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b1, "os_done");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, "os_after");

    // Wrapping auto-reload: term below load.
    cfg_ld = 6; cfg_tm = 1; cfg_ar = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b0, "wrap_start");
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, t3_cnt[i], 1'b1, t3_done[i], "wrap_count");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b0, "wrap_stop");

    // Pause at 3 for three clocks, resume, then stop.
    cfg_ld = 0; cfg_tm = 7; cfg_ar = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, "pause_start");
    for (int i = 1; i <= 3; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, i, 1'b1, 1'b0, "pause_count");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, "pause_hold");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, "pause_resume");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, "pause_run");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, "pause_stop");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, "pause_idle");

    // Simultaneous stop/start, restart in RUN, stop on terminal count.
    cfg_ld = 2; cfg_tm = 7; cfg_ar = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, "sim_start");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, "sim_tick");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, "sim_stopstart_run");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, "sim_stopstart_idle");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, "sim_start2");
    for (int i = 3; i <= 5; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, i, 1'b1, 1'b0, "sim_count");
    cfg_ld = 1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, "sim_restart");
    cfg_tm = 3;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, "sim_count2");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, "sim_count2");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, "sim_stop_at_term");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, "sim_idle");

    // load_val == term_val fires on the first tick.
    cfg_ld = 5; cfg_tm = 5; cfg_ar = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0, "eq_start");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b1, "eq_done");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "eq_after");
`endif

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
